// File: rtl/spi_ip_slave_engine_if.sv
// Word-level handshake between the SPI slave shift engine and the register/FIFO layer.
// The engine uses the slave modport; the register/FIFO layer uses the master modport.
interface spi_ip_slave_engine_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] se_tx_data_i;
  logic                  se_tx_valid_i;
  logic                  se_tx_ready_o;
  logic [DATA_WIDTH-1:0] se_rx_data_o;
  logic                  se_rx_valid_o;
  logic                  se_tx_underrun_o;

  modport master (
    output se_tx_data_i, se_tx_valid_i,
    input  se_tx_ready_o, se_rx_data_o, se_rx_valid_o, se_tx_underrun_o
  );

  modport slave (
    input  se_tx_data_i, se_tx_valid_i,
    output se_tx_ready_o, se_rx_data_o, se_rx_valid_o, se_tx_underrun_o
  );
endinterface

// File: rtl/spi_ip_slave_engine.sv
// SPI slave shift engine: oversamples SCK/SS_n/MOSI on the system clock and handles all CPOL/CPHA modes.
// Received words leave as one-cycle pulses; transmit words enter through a one-entry holding register.
module spi_ip_slave_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic        IDLE_FILL  = 1'b1
) (
  input  logic                 se_clk_i,
  input  logic                 se_rst_i,
  input  logic                 se_sck_pol_i,
  input  logic                 se_sck_pha_i,
  input  logic                 se_sck_i,
  input  logic                 se_ss_n_i,
  input  logic                 se_mosi_i,
  output logic                 se_miso_o,
  output logic                 se_miso_oe_o,
  output logic                 se_busy_o,
  spi_ip_slave_engine_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  state_e                state_q, state_d;
  logic                  sck_s1_q, sck_s2_q, sck_prev_q;
  logic                  ss_s1_q, ss_s2_q;
  logic                  mosi_s1_q, mosi_s2_q;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;

  logic sck_edge, lead_edge, trail_edge, sample_edge, launch_edge;
  logic tx_write, take;

  assign sck_edge    = sck_s2_q ^ sck_prev_q;
  assign lead_edge   = sck_edge && (sck_s2_q != cpol_q);
  assign trail_edge  = sck_edge && (sck_s2_q == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign launch_edge = cpha_q ? lead_edge : trail_edge;
  assign tx_write    = bus.se_tx_valid_i && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    hold_d      = hold_q;
    take        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ss_s2_q) begin
          state_d = ST_ACTIVE;
          cpol_d  = se_sck_pol_i;
          cpha_d  = se_sck_pha_i;
          cnt_d   = '0;
          // CPHA=0 launches bit 0 before any clock edge, so word 0 is taken on entry
          take    = !se_sck_pha_i;
        end
      end
      ST_ACTIVE: begin
        if (ss_s2_q) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};
            if (cnt_q == LAST_BIT) begin
              cnt_d      = '0;
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          // A launch with the counter at zero is the launch of bit 0 of a new word
          if (launch_edge) begin
            if (cnt_q == '0) begin
              take = 1'b1;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
    endcase

    if (take) begin
      tx_shift_d = hold_full_q ? hold_q : {DATA_WIDTH{IDLE_FILL}};
      underrun_d = !hold_full_q;
    end

    // A write landing with an empty-holding take is kept for the following take
    hold_full_d = (hold_full_q && !take) || tx_write;
    if (tx_write) begin
      hold_d = bus.se_tx_data_i;
    end
  end

  always_ff @(posedge se_clk_i) begin
    if (se_rst_i) begin
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_prev_q  <= 1'b0;
      ss_s1_q     <= 1'b1;
      ss_s2_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      state_q     <= ST_IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      sck_s1_q    <= se_sck_i;
      sck_s2_q    <= sck_s1_q;
      sck_prev_q  <= sck_s2_q;
      ss_s1_q     <= se_ss_n_i;
      ss_s2_q     <= ss_s1_q;
      mosi_s1_q   <= se_mosi_i;
      mosi_s2_q   <= mosi_s1_q;
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign se_miso_o            = tx_shift_q[DATA_WIDTH-1];
  assign se_miso_oe_o         = (state_q == ST_ACTIVE);
  assign se_busy_o            = (state_q == ST_ACTIVE);
  assign bus.se_tx_ready_o    = !hold_full_q;
  assign bus.se_rx_data_o     = rx_data_q;
  assign bus.se_rx_valid_o    = rx_valid_q;
  assign bus.se_tx_underrun_o = underrun_q;

endmodule
